// File: rtl/clock_period_meter.sv
// Measures period and high time of a slow asynchronous signal in clk cycles, with lock and timeout status.
// Optional duty measurement is built when CLOCK_PERIOD_METER_DUTY_EN is defined; otherwise high_cycles is 0.
module clock_period_meter #(
   parameter int unsigned SYNC_STAGES    = 2,
   parameter int unsigned CNT_WIDTH      = 32,
   parameter int unsigned TIMEOUT_CYCLES = 100_000_000,
   parameter int unsigned LOCK_COUNT     = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 sig_in,
   input  logic                 enable,
   output logic [CNT_WIDTH-1:0] period_cycles,
   output logic [CNT_WIDTH-1:0] high_cycles,
   output logic                 valid,
   output logic                 locked,
   output logic                 timeout,
   output logic                 edge_pulse
);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WAIT_FIRST = 2'd1,
      MEASURE    = 2'd2
   } state_t;

   localparam int unsigned          LW      = $clog2(LOCK_COUNT + 1);
   localparam logic [CNT_WIDTH-1:0] TO_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
   localparam logic [LW-1:0]        LOCK_N  = LW'(LOCK_COUNT);

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   sig_d_q, sig_d_d;
   logic [CNT_WIDTH-1:0]   cnt_q, cnt_d, cnt_inc;
   logic [CNT_WIDTH-1:0]   period_q, period_d;
   logic [LW-1:0]          lock_cnt_q, lock_cnt_d;
   logic                   valid_q, valid_d;
   logic                   locked_q, locked_d;
   logic                   timeout_q, timeout_d;
   logic                   edge_q, edge_d;
   logic                   s, rise;

   assign sync_d  = {sync_q[SYNC_STAGES-2:0], sig_in};
   assign s       = sync_q[SYNC_STAGES-1];
   assign sig_d_d = s;
   assign rise    = s & ~sig_d_q;
   assign cnt_inc = cnt_q + 1'b1;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      period_d   = period_q;
      lock_cnt_d = lock_cnt_q;
      valid_d    = 1'b0;
      locked_d   = locked_q;
      timeout_d  = timeout_q;
      edge_d     = rise && (state_q != IDLE);
      if (!enable) begin
         state_d    = IDLE;
         cnt_d      = '0;
         lock_cnt_d = '0;
         locked_d   = 1'b0;
         timeout_d  = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               cnt_d      = '0;
               lock_cnt_d = '0;
               locked_d   = 1'b0;
               timeout_d  = 1'b0;
               state_d    = WAIT_FIRST;
            end
            WAIT_FIRST: begin
               cnt_d = cnt_inc;
               if (rise) begin
                  cnt_d      = '0;
                  lock_cnt_d = '0;
                  state_d    = MEASURE;
               end else if (cnt_q == TO_LAST) begin
                  timeout_d = 1'b1;
                  cnt_d     = '0;
               end
            end
            MEASURE: begin
               cnt_d = cnt_inc;
               if (rise) begin
                  period_d  = cnt_inc;
                  valid_d   = 1'b1;
                  timeout_d = 1'b0;
                  cnt_d     = '0;
                  // lock_cnt==0 marks the first measurement since entering MEASURE
                  if (lock_cnt_q == '0 || cnt_inc != period_q)
                     lock_cnt_d = LW'(1);
                  else if (lock_cnt_q < LOCK_N)
                     lock_cnt_d = lock_cnt_q + 1'b1;
                  locked_d = (lock_cnt_d >= LOCK_N);
               end else if (cnt_q == TO_LAST) begin
                  timeout_d  = 1'b1;
                  locked_d   = 1'b0;
                  lock_cnt_d = '0;
                  cnt_d      = '0;
                  state_d    = WAIT_FIRST;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         sync_q     <= '0;
         sig_d_q    <= 1'b0;
         cnt_q      <= '0;
         period_q   <= '0;
         lock_cnt_q <= '0;
         valid_q    <= 1'b0;
         locked_q   <= 1'b0;
         timeout_q  <= 1'b0;
         edge_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         sync_q     <= sync_d;
         sig_d_q    <= sig_d_d;
         cnt_q      <= cnt_d;
         period_q   <= period_d;
         lock_cnt_q <= lock_cnt_d;
         valid_q    <= valid_d;
         locked_q   <= locked_d;
         timeout_q  <= timeout_d;
         edge_q     <= edge_d;
      end
   end

`ifdef CLOCK_PERIOD_METER_DUTY_EN
   logic [CNT_WIDTH-1:0] hcnt_q, hcnt_d;
   logic [CNT_WIDTH-1:0] high_q, high_d;

   // Counting on sig_d covers the starting rise cycle (s already high) and excludes the closing one.
   always_comb begin
      hcnt_d = '0;
      high_d = high_q;
      if (enable && state_q == MEASURE) begin
         if (rise) begin
            high_d = hcnt_q;
            hcnt_d = '0;
         end else begin
            hcnt_d = hcnt_q + CNT_WIDTH'(sig_d_q);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hcnt_q <= '0;
         high_q <= '0;
      end else begin
         hcnt_q <= hcnt_d;
         high_q <= high_d;
      end
   end

   assign high_cycles = high_q;
`else
   assign high_cycles = '0;
`endif

   assign period_cycles = period_q;
   assign valid         = valid_q;
   assign locked        = locked_q;
   assign timeout       = timeout_q;
   assign edge_pulse    = edge_q;

endmodule

// File: tb/tb_clock_period_meter.sv
// Directed self-checking bench for clock_period_meter (TIMEOUT_CYCLES=64, LOCK_COUNT=2, SYNC_STAGES=2).
module tb_clock_period_meter;

   localparam int unsigned CW = 16;
`ifdef CLOCK_PERIOD_METER_DUTY_EN
   localparam bit DUTY = 1'b1;
`else
   localparam bit DUTY = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          sig_in;
   logic          enable;
   logic [CW-1:0] period_cycles;
   logic [CW-1:0] high_cycles;
   logic          valid, locked, timeout, edge_pulse;

   int checks = 0;
   int errors = 0;

   // waveform generator state, advanced on negedge
   bit gen_on   = 1'b0;
   int gen_high = 5;
   int gen_low  = 5;
   int ph       = 0;

   clock_period_meter #(
      .SYNC_STAGES   (2),
      .CNT_WIDTH     (CW),
      .TIMEOUT_CYCLES(64),
      .LOCK_COUNT    (2)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .sig_in       (sig_in),
      .enable       (enable),
      .period_cycles(period_cycles),
      .high_cycles  (high_cycles),
      .valid        (valid),
      .locked       (locked),
      .timeout      (timeout),
      .edge_pulse   (edge_pulse)
   );

   always #5 clk = ~clk;

   initial begin
      sig_in = 1'b0;
      forever begin
         @(negedge clk);
         if (gen_on) begin
            sig_in = (ph < gen_high);
            ph = (ph + 1 >= gen_high + gen_low) ? 0 : ph + 1;
         end else begin
            sig_in = 1'b0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input int budget, output bit got, output int cycles, output int edges);
      got = 1'b0; cycles = 0; edges = 0;
      while (!got && cycles < budget) begin
         tick();
         cycles++;
         if (edge_pulse) edges++;
         if (valid) got = 1'b1;
      end
   endtask

   function automatic logic [CW-1:0] exp_high(input int h);
      return DUTY ? CW'(h) : '0;
   endfunction

   task automatic test_reset();
      rst_n = 1'b0; enable = 1'b0;
      #3;
      checks++; if (period_cycles !== '0) begin errors++; $display("FAIL reset_period got %0d exp 0", period_cycles); end
      checks++; if (high_cycles !== '0) begin errors++; $display("FAIL reset_high got %0d exp 0", high_cycles); end
      checks++; if ({valid, locked, timeout, edge_pulse} !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b exp 0000", {valid, locked, timeout, edge_pulse}); end
      tick(); tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      bit got; int cyc, edg;
      gen_high = 5; gen_low = 5; ph = 0; gen_on = 1'b1; enable = 1'b1;
      wait_valid(60, got, cyc, edg);
      checks++; if (!got) begin errors++; $display("FAIL basic_first_valid got none exp valid"); end
      checks++; if (edg !== 2) begin errors++; $display("FAIL basic_edges_before_valid got %0d exp 2", edg); end
      checks++; if (period_cycles !== CW'(10)) begin errors++; $display("FAIL basic_period got %0d exp 10", period_cycles); end
      checks++; if (high_cycles !== exp_high(5)) begin errors++; $display("FAIL basic_high got %0d exp %0d", high_cycles, exp_high(5)); end
      checks++; if (locked !== 1'b0) begin errors++; $display("FAIL basic_unlocked_first got %b exp 0", locked); end
      tick();
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL basic_valid_pulse got %b exp 0", valid); end
      wait_valid(30, got, cyc, edg);
      checks++; if (!got || cyc !== 9) begin errors++; $display("FAIL basic_spacing got %0d exp 9 (got=%0b)", cyc, got); end
      checks++; if (period_cycles !== CW'(10)) begin errors++; $display("FAIL basic_period2 got %0d exp 10", period_cycles); end
      checks++; if (locked !== 1'b1) begin errors++; $display("FAIL basic_locked got %b exp 1", locked); end
   endtask

   task automatic test_duty();
      bit got; int cyc, edg;
      // sig_in rose 3 negedges ago; phase 3 of 3/7 continues as low
      gen_high = 3; gen_low = 7; ph = 3;
      wait_valid(30, got, cyc, edg);
      checks++; if (!got || cyc !== 10) begin errors++; $display("FAIL duty_spacing got %0d exp 10 (got=%0b)", cyc, got); end
      checks++; if (period_cycles !== CW'(10)) begin errors++; $display("FAIL duty_period got %0d exp 10", period_cycles); end
      checks++; if (high_cycles !== exp_high(3)) begin errors++; $display("FAIL duty_high got %0d exp %0d", high_cycles, exp_high(3)); end
      checks++; if (locked !== 1'b1) begin errors++; $display("FAIL duty_locked got %b exp 1", locked); end
   endtask

   task automatic test_timeout();
      bit got; int cyc, edg;
      gen_on = 1'b0;
      for (int i = 1; i <= 64; i++) begin
         tick();
         if (i == 63) begin
            checks++; if (timeout !== 1'b0 || locked !== 1'b1) begin errors++; $display("FAIL timeout_early got to=%b lk=%b exp to=0 lk=1", timeout, locked); end
         end
      end
      checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL timeout_set got %b exp 1", timeout); end
      checks++; if (locked !== 1'b0) begin errors++; $display("FAIL timeout_unlock got %b exp 0", locked); end
      for (int i = 0; i < 70; i++) tick();
      checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL timeout_sticky got %b exp 1", timeout); end
      gen_high = 4; gen_low = 4; ph = 0; gen_on = 1'b1;
      wait_valid(40, got, cyc, edg);
      checks++; if (!got || edg !== 2) begin errors++; $display("FAIL restart_edges got %0d exp 2 (got=%0b)", edg, got); end
      checks++; if (period_cycles !== CW'(8)) begin errors++; $display("FAIL restart_period got %0d exp 8", period_cycles); end
      checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL restart_timeout_clear got %b exp 0", timeout); end
   endtask

   task automatic test_period_change();
      bit got; int cyc, edg;
      gen_high = 5; gen_low = 5; ph = 3;
      for (int k = 0; k < 3; k++) wait_valid(30, got, cyc, edg);
      checks++; if (!got || period_cycles !== CW'(10) || locked !== 1'b1) begin errors++; $display("FAIL change_prelock got p=%0d lk=%b exp p=10 lk=1", period_cycles, locked); end
      gen_high = 6; gen_low = 6; ph = 3;
      wait_valid(30, got, cyc, edg);
      checks++; if (!got || period_cycles !== CW'(12)) begin errors++; $display("FAIL change_period got %0d exp 12", period_cycles); end
      checks++; if (locked !== 1'b0) begin errors++; $display("FAIL change_unlock got %b exp 0", locked); end
      wait_valid(30, got, cyc, edg);
      checks++; if (!got || period_cycles !== CW'(12) || cyc !== 12) begin errors++; $display("FAIL change_period2 got p=%0d cyc=%0d exp p=12 cyc=12", period_cycles, cyc); end
      checks++; if (locked !== 1'b1) begin errors++; $display("FAIL change_relock got %b exp 1", locked); end
   endtask

   task automatic test_enable_rise();
      for (int i = 0; i < 11; i++) tick();
      enable = 1'b0;
      tick();
      checks++; if (edge_pulse !== 1'b1) begin errors++; $display("FAIL en_rise_edge got %b exp 1", edge_pulse); end
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL en_rise_valid got %b exp 0", valid); end
      checks++; if (locked !== 1'b0 || timeout !== 1'b0) begin errors++; $display("FAIL en_rise_flags got lk=%b to=%b exp 0 0", locked, timeout); end
      checks++; if (period_cycles !== CW'(12)) begin errors++; $display("FAIL en_rise_period_keep got %0d exp 12", period_cycles); end
      tick();
      checks++; if (edge_pulse !== 1'b0 || valid !== 1'b0) begin errors++; $display("FAIL idle_quiet got e=%b v=%b exp 0 0", edge_pulse, valid); end
   endtask

   task automatic test_reset_mid();
      bit got; int cyc, edg;
      enable = 1'b1;
      wait_valid(60, got, cyc, edg);
      wait_valid(30, got, cyc, edg);
      tick(); tick(); tick();
      #2 rst_n = 1'b0;
      #1;
      checks++; if (period_cycles !== '0 || high_cycles !== '0) begin errors++; $display("FAIL rstmid_meas got p=%0d h=%0d exp 0 0", period_cycles, high_cycles); end
      checks++; if ({valid, locked, timeout, edge_pulse} !== 4'b0000) begin errors++; $display("FAIL rstmid_flags got %b exp 0000", {valid, locked, timeout, edge_pulse}); end
      gen_on = 1'b0;
      tick(); tick(); tick();
      rst_n = 1'b1;
      tick();
      gen_high = 6; gen_low = 6; ph = 0; gen_on = 1'b1;
      wait_valid(60, got, cyc, edg);
      checks++; if (!got || edg !== 2) begin errors++; $display("FAIL rstmid_edges got %0d exp 2 (got=%0b)", edg, got); end
      checks++; if (period_cycles !== CW'(12) || locked !== 1'b0) begin errors++; $display("FAIL rstmid_period got p=%0d lk=%b exp p=12 lk=0", period_cycles, locked); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_basic();
      test_duty();
      test_timeout();
      test_period_change();
      test_enable_rise();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
